// File: rtl/popcount_seq_unit.sv
// popcount_seq_unit: multi-cycle population count of a 100-bit word.
// The unit accepts a word on the input stream, then counts NBITS_PER_CYCLE bits
// per cycle. After 100/NBITS_PER_CYCLE cycles it presents the count on the
// output stream and holds it until the consumer accepts it.
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        synchronous active-high reset
//   istream_val  input word valid
//   istream_rdy  unit idle and able to take a word
//   istream_msg  100-bit word to count
//   ostream_val  result valid
//   ostream_rdy  consumer ready for the result
//   ostream_msg  7-bit result (0..100), held until the next result
module popcount_seq_unit #(
  parameter int unsigned NBITS_PER_CYCLE = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        istream_val,
  output logic        istream_rdy,
  input  logic [99:0] istream_msg,
  output logic        ostream_val,
  input  logic        ostream_rdy,
  output logic [6:0]  ostream_msg
);

  localparam int unsigned WORD_W = 100;
  localparam int unsigned ACC_W  = 7;
  localparam int unsigned STEPS  = WORD_W / NBITS_PER_CYCLE;
  localparam int unsigned CNT_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned PART_W = $clog2(NBITS_PER_CYCLE + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WORD_W-1:0] shreg;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [ACC_W-1:0]  result;
  logic [CNT_W-1:0]  step;
  logic [PART_W-1:0] partial;
  logic              in_fire;
  logic              out_fire;
  logic              last_step;

  // Handshake flags decode state only; reset forces both low.
  assign istream_rdy = !reset && (state == IDLE);
  assign ostream_val = !reset && (state == DONE);
  assign ostream_msg = result;

  assign in_fire   = istream_val && istream_rdy;
  assign out_fire  = ostream_val && ostream_rdy;
  assign last_step = (step == CNT_W'(STEPS - 1));

  // Popcount of the low slice of the shift register.
  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < NBITS_PER_CYCLE; i++) begin
      partial = partial + PART_W'(shreg[i]);
    end
  end

  assign acc_sum = acc + ACC_W'(partial);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_fire)   state_nxt = CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    if (out_fire)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch word, shift/accumulate, capture result on the final step.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg  <= '0;
      acc    <= '0;
      step   <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            shreg <= istream_msg;
            acc   <= '0;
            step  <= '0;
          end
        end
        CALC: begin
          acc   <= acc_sum;
          shreg <= shreg >> NBITS_PER_CYCLE;
          step  <= step + CNT_W'(1);
          // Result register only changes here, so it holds through IDLE/CALC.
          if (last_step) result <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule
